// File: rtl/servo_pkg.sv
// Shared register map, field positions and pulse-width clamp for servo_pwm_ctrl.
package servo_pkg;

    localparam int unsigned CTRL_ADDR      = 0;
    localparam int unsigned CH_MASK_ADDR   = 1;
    localparam int unsigned STATUS_ADDR    = 2;
    localparam int unsigned PW_BASE        = 4;

    localparam int unsigned EN_BIT         = 0;
    localparam int unsigned FRAME_DONE_BIT = 0;
    localparam int unsigned STATUS_CNT_LSB = 16;

    function automatic logic [31:0] clamp_pw(
        input logic [31:0] val,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Shared prescaler and frame counter; both are held at zero while disabled.
module servo_frame_timer #(
    parameter int unsigned CLK_DIV     = 50,
    parameter int unsigned FRAME_TICKS = 20000,
    parameter int unsigned PW_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            en_rise,
    output logic            tick,
    output logic [PW_W-1:0] frame_cnt,
    output logic            frame_start
);

    localparam int unsigned PS_W = $clog2(CLK_DIV);

    logic [PS_W-1:0] presc_q, presc_d;
    logic [PW_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick        = en && (presc_q == PS_W'(CLK_DIV - 1));
        frame_start = tick && (cnt_q == PW_W'(FRAME_TICKS - 1));
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        // Enabling always begins a fresh frame at count zero.
        if (!en || en_rise) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            cnt_d   = frame_start ? '0 : cnt_q + PW_W'(1);
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frame_cnt = cnt_q;

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Multi-channel RC-servo PWM generator with an Avalon-MM register interface.
// Pulse widths and channel mask are double-buffered into shadows at each frame start.
module servo_pwm_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH      = 6,
    parameter int unsigned CLK_DIV     = 50,
    parameter int unsigned FRAME_TICKS = 20000,
    parameter int unsigned PW_W        = 16,
    parameter int unsigned MIN_PW      = 500,
    parameter int unsigned MAX_PW      = 2500,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port
);

    localparam logic [PW_W-1:0] PW_RST = PW_W'((MIN_PW + MAX_PW) / 2);

    logic                         en_q, en_d;
    logic [NUM_CH-1:0]            ch_mask_q, ch_mask_d;
    logic                         frame_done_q, frame_done_d;
    logic [NUM_CH-1:0][PW_W-1:0]  pw_q, pw_d;
    logic [NUM_CH-1:0][PW_W-1:0]  pw_sh_q, pw_sh_d;
    logic [NUM_CH-1:0]            mask_sh_q, mask_sh_d;
    logic [NUM_CH-1:0]            out_q, out_d;

    logic            wr, wr_ctrl, wr_mask, wr_status;
    logic            en_rise, load_sh;
    logic            tick, frame_start;
    logic [PW_W-1:0] frame_cnt;
    logic            unused_sig;

    servo_frame_timer #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_TICKS (FRAME_TICKS),
        .PW_W        (PW_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (en_q),
        .en_rise     (en_rise),
        .tick        (tick),
        .frame_cnt   (frame_cnt),
        .frame_start (frame_start)
    );

    always_comb begin
        wr        = chipselect && !write_n;
        wr_ctrl   = wr && (address == ADDR_W'(CTRL_ADDR));
        wr_mask   = wr && (address == ADDR_W'(CH_MASK_ADDR));
        wr_status = wr && (address == ADDR_W'(STATUS_ADDR));
        en_rise   = wr_ctrl && writedata[EN_BIT] && !en_q;
        load_sh   = frame_start || en_rise;

        en_d      = wr_ctrl ? writedata[EN_BIT] : en_q;
        ch_mask_d = wr_mask ? writedata[NUM_CH-1:0] : ch_mask_q;

        // A frame start in the same cycle as a clear keeps the flag set.
        frame_done_d = frame_done_q;
        if (wr_status && writedata[FRAME_DONE_BIT]) frame_done_d = 1'b0;
        if (frame_start) frame_done_d = 1'b1;

        pw_d = pw_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr && (address == ADDR_W'(PW_BASE + i))) begin
                pw_d[i] = PW_W'(clamp_pw(32'(writedata[PW_W-1:0]), MIN_PW, MAX_PW));
            end
        end

        pw_sh_d   = load_sh ? pw_q : pw_sh_q;
        mask_sh_d = load_sh ? ch_mask_q : mask_sh_q;

        out_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            out_d[i] = en_q && mask_sh_q[i] && (frame_cnt < pw_sh_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q         <= 1'b0;
            ch_mask_q    <= '0;
            frame_done_q <= 1'b0;
            pw_q         <= {NUM_CH{PW_RST}};
            pw_sh_q      <= {NUM_CH{PW_RST}};
            mask_sh_q    <= '0;
            out_q        <= '0;
        end else begin
            en_q         <= en_d;
            ch_mask_q    <= ch_mask_d;
            frame_done_q <= frame_done_d;
            pw_q         <= pw_d;
            pw_sh_q      <= pw_sh_d;
            mask_sh_q    <= mask_sh_d;
            out_q        <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        if (address == ADDR_W'(CTRL_ADDR)) begin
            readdata[EN_BIT] = en_q;
        end else if (address == ADDR_W'(CH_MASK_ADDR)) begin
            readdata = 32'(ch_mask_q);
        end else if (address == ADDR_W'(STATUS_ADDR)) begin
            readdata[FRAME_DONE_BIT]            = frame_done_q;
            readdata[STATUS_CNT_LSB +: 16]      = 16'(frame_cnt);
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_W'(PW_BASE + i)) readdata = 32'(pw_q[i]);
        end
    end

    assign out_port   = out_q;
    assign unused_sig = ^{writedata, tick};

endmodule
